// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory (DM) stage of the 16-bit pipeline.
//   DM_DATA_W / DM_ADDR_W : default word and RAM address widths
//   dm_word_t             : one data word
//   DM_RESET_VAL          : value loaded into ans_dm on reset
//   dm_op_t / dm_decode_op: classification of the EX-stage memory control bits
package dm_pkg;

  localparam int unsigned DM_DATA_W = 16;
  localparam int unsigned DM_ADDR_W = 8;

  typedef logic [DM_DATA_W-1:0] dm_word_t;

  localparam dm_word_t DM_RESET_VAL = 16'h0000;

  typedef enum logic [1:0] {
    DM_OP_NONE  = 2'd0,
    DM_OP_READ  = 2'd1,
    DM_OP_WRITE = 2'd2
  } dm_op_t;

  // rw is only meaningful when the access is enabled.
  function automatic dm_op_t dm_decode_op(input logic en, input logic rw);
    if (!en)     return DM_OP_NONE;
    else if (rw) return DM_OP_WRITE;
    else         return DM_OP_READ;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-addressed data RAM, DEPTH = 2**ADDR_W words of DATA_W bits.
//   clk   in  : write clock
//   we    in  : write enable, mem[waddr] <= wdata on rising edge
//   waddr in  : write address
//   wdata in  : write data
//   raddr in  : asynchronous read address
//   rdata out : mem[raddr], combinational
// Every word starts at zero so reads never return X.
module dm_ram
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W = DM_DATA_W,
  parameter int unsigned ADDR_W = DM_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_memory.sv
// Data-memory stage: word RAM access plus the registered DM-stage result.
//   clk            in  : clock, all state updates on rising edge
//   reset          in  : synchronous active-high; clears ans_dm, blocks RAM writes
//   ans_ex         in  : EX result; low ADDR_W bits are the RAM address, also bypass value
//   DM_data        in  : store data
//   mem_en_ex      in  : memory access enable
//   mem_rw_ex      in  : 1 = store, 0 = load (when enabled)
//   mem_mux_sel_dm in  : 1 = ans_dm takes memory data, 0 = ans_dm takes ans_ex
//   ans_dm         out : registered stage result, one clock after inputs
module data_memory
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W = DM_DATA_W,
  parameter int unsigned ADDR_W = DM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] DM_data,
  input  logic              mem_en_ex,
  input  logic              mem_rw_ex,
  input  logic              mem_mux_sel_dm,
  output logic [DATA_W-1:0] ans_dm
);

  logic [ADDR_W-1:0] addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] ans_dm_d;
  logic [DATA_W-1:0] ans_dm_q;
  dm_op_t            op;

  // Upper address bits are dropped, so accesses wrap modulo DEPTH.
  assign addr = ans_ex[ADDR_W-1:0];
  assign op   = dm_decode_op(mem_en_ex, mem_rw_ex);

  dm_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dm_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (addr),
    .wdata (DM_data),
    .raddr (addr),
    .rdata (ram_rdata)
  );

  always_comb begin
    ram_we   = 1'b0;
    mem_data = '0;
    unique case (op)
      DM_OP_READ:  mem_data = ram_rdata;
      // Write-through: a store forwards its own data rather than the old word.
      DM_OP_WRITE: begin
        mem_data = DM_data;
        ram_we   = !reset;
      end
      default:     mem_data = '0;
    endcase
  end

  always_comb begin
    ans_dm_d = mem_mux_sel_dm ? mem_data : ans_ex;
    if (reset) begin
      ans_dm_d = DATA_W'(DM_RESET_VAL);
    end
  end

  always_ff @(posedge clk) begin
    ans_dm_q <= ans_dm_d;
  end

  assign ans_dm = ans_dm_q;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ans_ex;
  logic [15:0] DM_data;
  logic        mem_en_ex;
  logic        mem_rw_ex;
  logic        mem_mux_sel_dm;
  logic [15:0] ans_dm;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Reference model: plain word array and expected output.
  logic [15:0] model_mem [256];
  logic [15:0] exp_dm;

  data_memory #(
    .DATA_W (16),
    .ADDR_W (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ans_ex         (ans_ex),
    .DM_data        (DM_data),
    .mem_en_ex      (mem_en_ex),
    .mem_rw_ex      (mem_rw_ex),
    .mem_mux_sel_dm (mem_mux_sel_dm),
    .ans_dm         (ans_dm)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic rst, input logic [15:0] a,
                      input logic [15:0] d, input logic en, input logic rw,
                      input logic sel);
    logic [15:0] md;
    logic [7:0]  wa;
    reset          = rst;
    ans_ex         = a;
    DM_data        = d;
    mem_en_ex      = en;
    mem_rw_ex      = rw;
    mem_mux_sel_dm = sel;
    @(posedge clk);
    wa = a[7:0];
    if (rst) begin
      exp_dm = 16'h0000;
    end else begin
      if (!en)     md = 16'h0000;
      else if (rw) md = d;
      else         md = model_mem[wa];
      if (en && rw) model_mem[wa] = d;
      exp_dm = sel ? md : a;
    end
    #1;
    n_checks++;
    assert (ans_dm === exp_dm)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, ans_dm, exp_dm);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    exp_dm = 16'h0000;
    reset = 1'b1; ans_ex = '0; DM_data = '0;
    mem_en_ex = 1'b0; mem_rw_ex = 1'b0; mem_mux_sel_dm = 1'b0;

    // Reset with writes presented: output cleared, RAM untouched.
    step("reset0", 1'b1, 16'h0011, 16'hDEAD, 1'b1, 1'b1, 1'b1);
    step("reset1", 1'b1, 16'h0012, 16'hCAFE, 1'b1, 1'b1, 1'b0);
    step("rst_nowr_11", 1'b0, 16'h0011, 16'h0000, 1'b1, 1'b0, 1'b1);
    step("rst_nowr_12", 1'b0, 16'h0012, 16'h0000, 1'b1, 1'b0, 1'b1);

    step("bypass", 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
    step("read_unwritten", 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b1);
    step("write_through", 1'b0, 16'h0003, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    step("read_after_write", 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b1);

    step("gated_write", 1'b0, 16'h0005, 16'hAAAA, 1'b0, 1'b1, 1'b1);
    step("gated_readback", 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1);
    step("wrap_write", 1'b0, 16'h0105, 16'h5A5A, 1'b1, 1'b1, 1'b1);
    step("wrap_read", 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1);

    step("b2b_write1", 1'b0, 16'h0020, 16'h1111, 1'b1, 1'b1, 1'b0);
    step("b2b_write2", 1'b0, 16'h0020, 16'h2222, 1'b1, 1'b1, 1'b0);
    step("b2b_read", 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1);

    step("keep_write", 1'b0, 16'h0009, 16'h1357, 1'b1, 1'b1, 1'b1);
    step("keep_reset0", 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    step("keep_reset1", 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    step("keep_read", 1'b0, 16'h0009, 16'h0000, 1'b1, 1'b0, 1'b1);

    step("reset_during_write", 1'b1, 16'h0007, 16'hBEEF, 1'b1, 1'b1, 1'b1);
    step("read_after_rst_wr", 1'b0, 16'h0007, 16'h0000, 1'b1, 1'b0, 1'b1);
    step("sel_read_bypass", 1'b0, 16'hAB03, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Random traffic over a small address window with random upper bits.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      a = {8'($urandom), 8'($urandom_range(0, 15))};
      step("random", ($urandom_range(0, 31) == 0), a, 16'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Sweep every word to compare full RAM contents with the model.
    for (int i = 0; i < 256; i++) begin
      step("sweep", 1'b0, 16'(i) | 16'h0300, 16'h0000, 1'b1, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
